// File: rtl/systolic_pkg.sv
// Shared constants and state type for the systolic row feeder and its skew lanes.
package systolic_pkg;

  localparam int DW     = 16;
  localparam int LANES  = 4;
  localparam int DEPTH  = 32;
  localparam int AW     = 32;
  localparam int LANE_W = DW;
  localparam int ROW_W  = $clog2(DEPTH);
  localparam int COL_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Enabled shift line of STAGES registers followed by one output register;
// STAGES = 0 leaves only the output register.
module skew_delay_line #(
  parameter int STAGES = 1,
  parameter int W      = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_tap [STAGES+1];

  // shift chain, frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= STAGES; i++) begin
        r_tap[i] <= {W{1'b0}};
      end
    end else if (en) begin
      r_tap[0] <= d;
      for (int i = 1; i <= STAGES; i++) begin
        r_tap[i] <= r_tap[i-1];
      end
    end
  end

  assign q = r_tap[STAGES];

endmodule

// File: rtl/systolic_row_feeder.sv
// Streams rows of the 32x4 matrix memory into a diagonally skewed systolic edge:
// reads a row word by word, buffers it, then launches lane k delayed by k cycles.
module systolic_row_feeder
  import systolic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_W-1:0]      row_base,
  input  logic [ROW_W:0]        num_rows,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         mem_row,
  output logic [3:0]            mem_col,
  output logic                  mem_en,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic [LANES*DW-1:0]   lane_data,
  output logic [LANES-1:0]      lane_valid
);

  localparam logic [COL_W:0]   COL_END    = (COL_W+1)'(LANES);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LANES-1);
  localparam logic [COL_W-1:0] DRAIN_LAST = COL_W'(LANES-2);

  feeder_state_t    r_state, w_state_nxt;
  logic [ROW_W-1:0] r_base;
  logic [ROW_W:0]   r_num, r_row, w_row_inc;
  logic [COL_W:0]   r_col;
  logic             r_full;
  logic [DW-1:0]    r_buf [LANES];
  logic             r_iss_v, r_rd_v;
  logic [COL_W-1:0] r_iss_col, r_rd_col;
  logic [COL_W-1:0] r_drain_cnt;
  logic             r_busy, r_done;
  logic [ROW_W-1:0] r_mem_row;
  logic [3:0]       r_mem_col;

  logic             w_accept, w_launch, w_last, w_issue;
  logic [ROW_W-1:0] w_issue_row;
  logic [COL_W-1:0] w_issue_col;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state, launch and read-issue decisions
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_last      = 1'b0;
    w_issue     = 1'b0;
    w_row_inc   = r_row + {{ROW_W{1'b0}}, 1'b1};
    w_issue_row = r_base + r_row[ROW_W-1:0];
    w_issue_col = r_col[COL_W-1:0];
    case (r_state)
      IDLE: begin
        if (start && !r_busy) begin
          w_accept = 1'b1;
          if (num_rows == {(ROW_W+1){1'b0}}) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = READ;
            w_issue     = 1'b1;
            w_issue_row = row_base;
            w_issue_col = {COL_W{1'b0}};
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        w_launch = r_full && !hold;
        w_last   = (w_row_inc == r_num);
        // the next row's first read goes out on the launch edge itself
        if (w_launch && w_last) begin
          w_state_nxt = DRAIN;
        end else if (w_launch) begin
          w_issue     = 1'b1;
          w_issue_row = r_base + w_row_inc[ROW_W-1:0];
          w_issue_col = {COL_W{1'b0}};
        end else if (!r_full && (r_col < COL_END)) begin
          w_issue = 1'b1;
        end else begin
          w_issue = 1'b0;
        end
      end
      DRAIN: begin
        if (!hold && (r_drain_cnt == DRAIN_LAST)) w_state_nxt = FIN;
        else                                      w_state_nxt = DRAIN;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // counters, row buffer, memory address and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= {ROW_W{1'b0}};
      r_num       <= {(ROW_W+1){1'b0}};
      r_row       <= {(ROW_W+1){1'b0}};
      r_col       <= {(COL_W+1){1'b0}};
      r_full      <= 1'b0;
      r_iss_v     <= 1'b0;
      r_iss_col   <= {COL_W{1'b0}};
      r_rd_v      <= 1'b0;
      r_rd_col    <= {COL_W{1'b0}};
      r_drain_cnt <= {COL_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_row   <= {ROW_W{1'b0}};
      r_mem_col   <= 4'd0;
      for (int i = 0; i < LANES; i++) begin
        r_buf[i] <= {DW{1'b0}};
      end
    end else begin
      r_busy <= (r_state != IDLE) || (w_state_nxt != IDLE);
      r_done <= (r_state == FIN);
      if (w_accept) begin
        r_base <= row_base;
        r_num  <= num_rows;
      end
      if (w_accept)      r_row <= {(ROW_W+1){1'b0}};
      else if (w_launch) r_row <= w_row_inc;
      if (w_issue) begin
        r_mem_row <= w_issue_row;
        r_mem_col <= {{(4-COL_W){1'b0}}, w_issue_col};
        r_col     <= {1'b0, w_issue_col} + {{COL_W{1'b0}}, 1'b1};
      end else if (w_launch) begin
        r_col <= {(COL_W+1){1'b0}};
      end
      // read data arrives one cycle after the address is presented
      r_iss_v   <= w_issue;
      r_iss_col <= w_issue_col;
      r_rd_v    <= r_iss_v;
      r_rd_col  <= r_iss_col;
      if (r_rd_v) r_buf[r_rd_col] <= mem_rdata;
      if (w_launch)                             r_full <= 1'b0;
      else if (r_rd_v && (r_rd_col == COL_LAST)) r_full <= 1'b1;
      if (w_launch)                            r_drain_cnt <= {COL_W{1'b0}};
      else if ((r_state == DRAIN) && !hold)    r_drain_cnt <= r_drain_cnt + {{(COL_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW:0] w_d, w_q;
    assign w_d = w_launch ? {1'b1, r_buf[k]} : {(DW+1){1'b0}};
    skew_delay_line #(.STAGES(k), .W(DW+1)) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!hold),
      .d     (w_d),
      .q     (w_q)
    );
    assign lane_data[k*DW +: DW] = w_q[DW-1:0];
    assign lane_valid[k]         = w_q[DW];
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_row   = {{(AW-ROW_W){1'b0}}, r_mem_row};
  assign mem_col   = r_mem_col;
  assign mem_en    = 1'b0;
  assign mem_wdata = {DW{1'b0}};

endmodule

// File: doc/systolic_row_feeder.md
# systolic_row_feeder

Read-side initiator for the 32×4 matrix memory. On a start command it issues sequential reads over the memory's row/col/en port, assembles each 4-word row in a buffer, and launches the row into a diagonal skew so that lane k of the systolic array edge receives column k delayed by k cycles. It sits between the matrix memory and the left/top edge of the systolic array and never writes the memory.

## Interface
- `DW`, 16: data word width.
- `LANES`, 4: columns per row and array edge lanes. Fixed at 4 because `mem_col` addresses 0..3.
- `DEPTH`, 32: memory rows. Row indices wrap modulo `DEPTH`.
- `AW`, 32: width of the memory row address port.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle command. Ignored while `busy`.
- `row_base`  in  5: first memory row. Sampled with `start`.
- `num_rows`  in  6: number of rows to stream, 0..32. Sampled with `start`.
- `hold`  in  1: array stall. Freezes launch and skew shifting.
- `busy`  out  1: high from the cycle after `start` is accepted until the cycle after `done`.
- `done`  out  1: one-cycle completion pulse.
- `mem_row`  out  AW: `(row_base + r) mod 32`, zero-extended.
- `mem_col`  out  4: column being read, 0..3.
- `mem_en`  out  1: constant 0 (read).
- `mem_wdata`  out  DW: constant 0.
- `mem_rdata`  in  DW: memory read data. Valid the cycle after the address is presented.
- `lane_data`  out  LANES*DW: lane k occupies bits [16k+15:16k].
- `lane_valid`  out  LANES: per-lane valid, one bit per lane.

## Operation
- **Reset values:** every output is 0 (`mem_en`=0), state is IDLE, all counters are 0, and the buffer and skew registers are cleared. Reset asserted mid-run aborts immediately with no `done`.
- **FSM states:** IDLE, READ, DRAIN, FIN.
- **IDLE**
  - `start` with `num_rows`=0 → FIN.
  - `start` with `num_rows`>0 → READ. Row counter r=0, column counter c=0.
- **READ, issue:** a read issues when c<4 and the buffer is not full. Each issue drives `mem_row`, `mem_col`=c, then c++.
- **READ, capture:** `mem_rdata` is captured into `buf[c_cap]` the cycle after its issue. Capture of column 3 sets `full`.
- **READ, launch:** launch occurs when `full` && !`hold`. On launch:
  - `buf[k]` enters lane k's delay line;
  - `full` clears, c=0, r++.
  - If this was the last row, go to DRAIN.
- **READ, reads during hold:** reads are not blocked by `hold`. With `full` set, no further issue occurs, so data is never lost.
- **Skew:** lane k is a k-stage delay with enable !`hold`, followed by the output register. `lane_valid[k]` follows the launched token through the same stages.
  - When `hold`=1, `lane_data` and `lane_valid` keep their values.
- **DRAIN:** wait until all `lane_valid` bits have shifted out (3 non-held shifts after the last launch), then go to FIN.
- **FIN:** `done`=1 for one cycle, then IDLE. `busy` drops in the following cycle.
- `mem_row`/`mem_col` hold their last values when no read is issued. The memory ignores them because `mem_en`=0 still means read, and a repeated read is harmless.

## Timing
- `start` is accepted at edge E0; cycle n is the nth cycle after E0.
- **Row 0:** reads are issued in cycles 1–4 (cols 0–3), cycle 5 is idle (capture of col 3), and launch happens in cycle 6.
- **Lane outputs:** `lane_valid[k]` is high in cycle 7+k only (no hold).
- **Row period:** 6 cycles. Row r launches at cycle 6+6r.
- **N rows, no hold:** last `lane_valid[3]` in cycle 6N+4, `done` in cycle 6N+5, `busy` low in cycle 6N+6.
- **`num_rows`=0:** `done` in cycle 2, no memory issue.
- **Hold:** each cycle of `hold` during launch or skew delays every later event by one cycle.
- **Wrap:** `row_base`=30, `num_rows`=4 reads rows 30, 31, 0, 1.

## Structure
- **Shared package `systolic_pkg`:**
  - `DW`, `LANES`, `DEPTH` constants;
  - the `feeder_state_t` enum (IDLE, READ, DRAIN, FIN);
  - the lane slice width.
- **Sub-module `skew_delay_line`:** parameterized by stage count and width, with enable. Instantiated per lane with k stages; lane 0 has 0 stages and is a pass-through into the output register.

## Test plan
- **Single row:** memory row 5 = {A,B,C,D}, `row_base`=5, `num_rows`=1.
  - Addresses (5,0)…(5,3) appear in cycles 1–4.
  - `lane_data` lanes 0..3 show A,B,C,D in cycles 7,8,9,10.
  - `done` in cycle 11.
- **Full sweep:** `row_base`=0, `num_rows`=32, with mem[r][c]=16·r+c.
  - Every lane sees 16r+k in cycle 7+6r+k.
  - `done` in cycle 197.
- **Wrap:** `row_base`=30, `num_rows`=4. `mem_row` sequence is 30, 31, 0, 1 and data is correct.
- **Hold:** `hold` high for cycles 6–8 of row 0.
  - Launch slips to cycle 9.
  - Outputs are frozen during hold.
  - All later events shift by 3.
- **Degenerate cases:**
  - `num_rows`=0 gives `done` in cycle 2 with no reads.
  - `start` pulsed while `busy` is ignored.
- **Reset:** `rst_n` low in cycle 8.
  - All outputs go to 0 asynchronously and there is no `done`.
  - A new `start` after release behaves as the single-row case.
